// File: rtl/cdma_ahb2apb.sv
// AHB-Lite slave to APB master bridge for the cdma configuration port.
// Define CDMA_AHB2APB_TOUT_EN to abort APB accesses that stall for TOUT_CYC cycles.
module cdma_ahb2apb #(
  parameter int unsigned TOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWdata  = 3'd1;
  localparam logic [2:0] StSetup  = 3'd2;
  localparam logic [2:0] StAccess = 3'd3;
  localparam logic [2:0] StErr1   = 3'd4;
  localparam logic [2:0] StErr2   = 3'd5;

  logic [2:0] state_q, state_d;
  logic       accept;
  logic       bad_xfer;
  logic       tout_hit;
  logic       unused_sig;

  assign accept   = hsel & hready & htrans[1];
  assign bad_xfer = (hsize != 3'b010) | (haddr[1:0] != 2'b00);

`ifdef CDMA_AHB2APB_TOUT_EN
  localparam logic [7:0] ToutLim = TOUT_CYC[7:0];

  logic [7:0] tout_cnt_q;

  // Fires on the stalled ACCESS cycle that brings the count up to the limit.
  assign tout_hit = (state_q == StAccess) & ~pready & ((tout_cnt_q + 8'd1) == ToutLim);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tout_cnt_q <= 8'd0;
    end else if (state_d == StSetup) begin
      tout_cnt_q <= 8'd0;
    end else if ((state_q == StAccess) && !pready) begin
      tout_cnt_q <= tout_cnt_q + 8'd1;
    end
  end

  assign unused_sig = ^{haddr[31:8], htrans[0]};
`else
  assign tout_hit   = 1'b0;
  assign unused_sig = ^{haddr[31:8], htrans[0], TOUT_CYC};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bad_xfer)    state_d = StErr1;
          else if (hwrite) state_d = StWdata;
          else             state_d = StSetup;
        end
      end
      StWdata:  state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (pready)        state_d = StIdle;
        else if (tout_hit) state_d = StErr1;
      end
      StErr1:   state_d = StErr2;
      StErr2:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 8'd0;
      pwdata    <= 32'd0;
      hrdata    <= 32'd0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel      <= (state_d == StSetup) || (state_d == StAccess);
      penable   <= (state_d == StAccess);
      hreadyout <= (state_d == StIdle) || (state_d == StErr2);
      hresp     <= (state_d == StErr1) || (state_d == StErr2);
      if ((state_q == StIdle) && accept) begin
        paddr  <= haddr[7:0];
        pwrite <= hwrite;
      end
      if (state_q == StWdata) begin
        pwdata <= hwdata;
      end
      if ((state_q == StAccess) && pready && !pwrite) begin
        hrdata <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_cdma_ahb2apb.sv
// Directed self-checking bench for cdma_ahb2apb; the timeout scenario runs only
// when CDMA_AHB2APB_TOUT_EN is defined.
module tb_cdma_ahb2apb;

`ifdef CDMA_AHB2APB_TOUT_EN
  localparam int unsigned TbTout = 4;
`else
  localparam int unsigned TbTout = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;

  cdma_ahb2apb #(.TOUT_CYC(TbTout)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
  endtask

  task automatic test_reset();
    n_tests++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout); end
    n_tests++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b want 0", hresp); end
    n_tests++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_psel_penable: got %b%b want 00", psel, penable); end
    n_tests++; if (paddr !== 8'h00 || pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_paddr_pwrite: got %h/%b want 00/0", paddr, pwrite); end
    n_tests++; if (pwdata !== 32'h0 || hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", pwdata, hrdata); end
  endtask

  task automatic test_idle_busy();
    hsel = 1'b1; haddr = 32'h20; htrans = 2'b00; hsize = 3'b010;
    tick();
    htrans = 2'b01;
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL idle_trans: got rdy=%b resp=%b psel=%b want 1/0/0", hreadyout, hresp, psel); end
    tick();
    bus_idle();
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL busy_trans: got rdy=%b resp=%b psel=%b want 1/0/0", hreadyout, hresp, psel); end
  endtask

  task automatic test_read();
    pready = 1'b1; prdata = 32'hA5A5_1234;
    addr_phase(32'h0000_0010, 1'b0, 3'b010);
    tick();  // T+1
    bus_idle();
    n_tests++; if (psel !== 1'b1 || penable !== 1'b0 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL read_setup: got psel=%b pen=%b rdy=%b want 1/0/0", psel, penable, hreadyout); end
    n_tests++; if (paddr !== 8'h10 || pwrite !== 1'b0) begin n_fail++; $display("FAIL read_paddr: got %h/%b want 10/0", paddr, pwrite); end
    tick();  // T+2
    n_tests++; if (psel !== 1'b1 || penable !== 1'b1 || hreadyout !== 1'b0) begin n_fail++; $display("FAIL read_access: got psel=%b pen=%b rdy=%b want 1/1/0", psel, penable, hreadyout); end
    tick();  // T+3
    prdata = 32'h0;
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL read_done: got rdy=%b resp=%b psel=%b want 1/0/0", hreadyout, hresp, psel); end
    n_tests++; if (hrdata !== 32'hA5A5_1234) begin n_fail++; $display("FAIL read_hrdata: got %h want a5a51234", hrdata); end
  endtask

  task automatic test_write_wait();
    pready = 1'b0;
    addr_phase(32'h0000_0004, 1'b1, 3'b010);
    tick();  // T+1 data phase
    bus_idle();
    hwdata = 32'hDEAD_BEEF;
    n_tests++; if (hreadyout !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL write_wdata: got rdy=%b psel=%b want 0/0", hreadyout, psel); end
    tick();  // T+2 SETUP
    hwdata = 32'h0BAD_F00D;
    n_tests++; if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 8'h04) begin n_fail++; $display("FAIL write_setup: got psel=%b pen=%b pwr=%b paddr=%h want 1/0/1/04", psel, penable, pwrite, paddr); end
    n_tests++; if (pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_setup_pwdata: got %h want deadbeef", pwdata); end
    for (int c = 3; c <= 6; c++) begin
      tick();  // T+3..T+6 ACCESS
      if (c == 6) pready = 1'b1;
      n_tests++; if (psel !== 1'b1 || penable !== 1'b1 || hreadyout !== 1'b0 || pwdata !== 32'hDEAD_BEEF || paddr !== 8'h04) begin n_fail++; $display("FAIL write_access_T%0d: got psel=%b pen=%b rdy=%b pwdata=%h paddr=%h want 1/1/0/deadbeef/04", c, psel, penable, hreadyout, pwdata, paddr); end
    end
    tick();  // T+7
    pready = 1'b1;
    n_tests++; if (hreadyout !== 1'b1 || psel !== 1'b0 || hresp !== 1'b0) begin n_fail++; $display("FAIL write_done: got rdy=%b psel=%b resp=%b want 1/0/0", hreadyout, psel, hresp); end
    n_tests++; if (hrdata !== 32'hA5A5_1234) begin n_fail++; $display("FAIL write_keeps_hrdata: got %h want a5a51234", hrdata); end
  endtask

  task automatic run_error(input logic [31:0] a, input logic wr, input logic [2:0] sz, input string nm);
    addr_phase(a, wr, sz);
    tick();  // T+1
    bus_idle();
    n_tests++; if (hreadyout !== 1'b0 || hresp !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("FAIL %s_err1: got rdy=%b resp=%b psel=%b want 0/1/0", nm, hreadyout, hresp, psel); end
    tick();  // T+2
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b1 || psel !== 1'b0) begin n_fail++; $display("FAIL %s_err2: got rdy=%b resp=%b psel=%b want 1/1/0", nm, hreadyout, hresp, psel); end
    tick();  // T+3
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 1'b0) begin n_fail++; $display("FAIL %s_after: got rdy=%b resp=%b psel=%b want 1/0/0", nm, hreadyout, hresp, psel); end
  endtask

  task automatic test_error();
    run_error(32'h0000_0008, 1'b0, 3'b000, "err_hsize");
    run_error(32'h0000_000A, 1'b1, 3'b010, "err_align");
    n_tests++; if (hrdata !== 32'hA5A5_1234) begin n_fail++; $display("FAIL err_keeps_hrdata: got %h want a5a51234", hrdata); end
  endtask

  task automatic test_back_to_back();
    pready = 1'b1; prdata = 32'h1111_1111;
    addr_phase(32'h0000_0000, 1'b0, 3'b010);
    tick();  // T+1
    bus_idle();
    tick();  // T+2
    tick();  // T+3, hreadyout back high: pipeline second read
    n_tests++; if (hreadyout !== 1'b1 || hrdata !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_first: got rdy=%b hrdata=%h want 1/11111111", hreadyout, hrdata); end
    addr_phase(32'h0000_0004, 1'b0, 3'b010);
    prdata = 32'h2222_2222;
    tick();  // T+4
    bus_idle();
    n_tests++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 8'h04) begin n_fail++; $display("FAIL b2b_second_setup: got psel=%b pen=%b paddr=%h want 1/0/04", psel, penable, paddr); end
    tick();  // T+5
    tick();  // T+6
    n_tests++; if (hreadyout !== 1'b1 || hrdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_second: got rdy=%b hrdata=%h want 1/22222222", hreadyout, hrdata); end
  endtask

  task automatic test_reset_mid();
    pready = 1'b0; prdata = 32'h0;
    addr_phase(32'h0000_000C, 1'b0, 3'b010);
    tick();
    bus_idle();
    tick();  // ACCESS
    n_tests++; if (penable !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: got pen=%b want 1", penable); end
    #2 rstn = 1'b0;
    #1;
    n_tests++; if (psel !== 1'b0 || penable !== 1'b0 || hreadyout !== 1'b1 || hrdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_async: got psel=%b pen=%b rdy=%b hrdata=%h want 0/0/1/0", psel, penable, hreadyout, hrdata); end
    tick();
    rstn = 1'b1;
    tick();
    pready = 1'b1; prdata = 32'h5A5A_0F0F;
    addr_phase(32'h0000_0010, 1'b0, 3'b010);
    tick();
    bus_idle();
    n_tests++; if (psel !== 1'b1 || paddr !== 8'h10) begin n_fail++; $display("FAIL rstmid_next_setup: got psel=%b paddr=%h want 1/10", psel, paddr); end
    tick();
    tick();
    n_tests++; if (hreadyout !== 1'b1 || hrdata !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL rstmid_next_read: got rdy=%b hrdata=%h want 1/5a5a0f0f", hreadyout, hrdata); end
  endtask

`ifdef CDMA_AHB2APB_TOUT_EN
  task automatic test_timeout();
    pready = 1'b0; prdata = 32'hFFFF_0000;
    addr_phase(32'h0000_0014, 1'b0, 3'b010);
    tick();  // T+1 SETUP
    bus_idle();
    for (int c = 2; c <= 5; c++) begin
      tick();  // four ACCESS cycles
      n_tests++; if (psel !== 1'b1 || penable !== 1'b1) begin n_fail++; $display("FAIL tout_access_T%0d: got psel=%b pen=%b want 1/1", c, psel, penable); end
    end
    tick();  // T+6
    n_tests++; if (psel !== 1'b0 || penable !== 1'b0 || hreadyout !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL tout_err1: got psel=%b pen=%b rdy=%b resp=%b want 0/0/0/1", psel, penable, hreadyout, hresp); end
    tick();  // T+7
    n_tests++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL tout_err2: got rdy=%b resp=%b want 1/1", hreadyout, hresp); end
    n_tests++; if (hrdata !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL tout_hrdata: got %h want 5a5a0f0f", hrdata); end
    pready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rstn = 1'b0; hready = 1'b1; hwdata = 32'h0; pready = 1'b0; prdata = 32'h0;
    haddr = 32'h0;
    bus_idle();
    tick();
    tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_reset();
    test_idle_busy();
    test_read();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_reset_mid();
`ifdef CDMA_AHB2APB_TOUT_EN
    test_timeout();
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdma_ahb2apb.md
# cdma_ahb2apb

AHB-Lite slave to APB master bridge that sits directly upstream of the cdma configuration port and drives its psel/penable/paddr/pwrite/pwdata, consuming pready/prdata. It converts single 32-bit AHB register accesses from the system bus into two-phase APB transfers. It stretches the AHB data phase with hreadyout until the APB access completes. Unsupported accesses are rejected with a two-cycle AHB ERROR response and no APB transfer.

## Interface
- TOUT_CYC, 255: APB ACCESS-phase cycle limit; used only when CDMA_AHB2APB_TOUT_EN is defined.
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- hsel  in  1  slave select
- haddr  in  32  byte address; [7:0] forwarded as paddr
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1 = write
- hsize  in  3  only 3'b010 (word) supported
- hwdata  in  32  write data, valid in the data phase
- hready  in  1  bus-level ready; qualifies the address phase
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  32  read data
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  8  APB byte address
- pwdata  out  32  APB write data
- pready  in  1  APB ready
- prdata  in  32  APB read data

## Operation
- Transfer is accepted when `hsel & hready & htrans[1]`. On acceptance, haddr[7:0] and hwrite are registered.
- The transfer is an error when `hsize != 3'b010` or `haddr[1:0] != 0`. haddr[31:8] is ignored.
- hsel with IDLE or BUSY: OKAY, zero wait, no state change.
- FSM states and transitions:
  - IDLE:
    - valid accepted read -> SETUP
    - valid accepted write -> WDATA
    - error -> ERR1
  - WDATA: pwdata <= hwdata; -> SETUP.
  - SETUP: psel=1, penable=0; -> ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1 -> IDLE; on a read, hrdata <= prdata.
    - pready=0 -> stay in ACCESS.
  - ERR1: hreadyout=0, hresp=1; -> ERR2.
  - ERR2: hreadyout=1, hresp=1; -> IDLE.
- All outputs are registered. paddr, pwrite and pwdata hold stable from SETUP through ACCESS completion.
- hreadyout:
  - cleared on any accepted NONSEQ/SEQ transfer;
  - set in the cycle after ACCESS & pready;
  - set in ERR2.
- hrdata holds its last value until the next completed read. Writes leave hrdata unchanged.
- No new transfer is accepted while the state is not IDLE; hreadyout=0 guarantees this. A pipelined address phase in the cycle hreadyout returns high is accepted normally from IDLE.
- Reset, including mid-transfer: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hreadyout=1, hresp=0. Any in-flight APB access is abandoned.

## Timing
- Read, address phase at cycle T:
  - T+1: SETUP.
  - T+2: ACCESS.
  - If pready=1 at T+2: hreadyout=1 and hrdata valid at T+3.
  - Each cycle pready stays low adds one cycle.
- Write: one extra WDATA cycle. SETUP at T+2, ACCESS at T+3, hreadyout=1 at T+4 with zero APB wait.
- Error: hreadyout=0 and hresp=1 at T+1; hreadyout=1 and hresp=1 at T+2; OKAY idle at T+3.
- Minimum back-to-back read throughput: one transfer per 3 cycles.

## Configuration
- CDMA_AHB2APB_TOUT_EN defined:
  - An 8-bit or wider counter clears on entry to SETUP and increments each ACCESS cycle with pready=0.
  - When the count reaches TOUT_CYC: psel and penable drop to 0, the state goes to ERR1, and hrdata is unchanged.
  - pready=1 in the same cycle the count reaches TOUT_CYC counts as success; no error.
- CDMA_AHB2APB_TOUT_EN undefined: no counter; ACCESS waits on pready indefinitely; TOUT_CYC is unused.

## Test plan
- Read 0x0000_0010, pready=1, prdata=0xA5A5_1234:
  - paddr=0x10; SETUP at T+1, ACCESS at T+2;
  - hreadyout=1 and hrdata=0xA5A5_1234 at T+3.
- Write 0x0000_0004 with hwdata=0xDEAD_BEEF and 3 pready wait cycles:
  - pwdata=0xDEAD_BEEF stable across SETUP and ACCESS;
  - hreadyout=1 at T+7.
- hsize=3'b000 read at 0x08, then haddr=0x0A word write:
  - each gets two-cycle ERROR (hresp=1 at T+1 and T+2);
  - psel never asserted.
- Back-to-back pipelined reads 0x00 then 0x04, second address phase presented in the cycle hreadyout returns high:
  - second read accepted, paddr=0x04, correct data.
- rstn low during ACCESS:
  - psel=0, penable=0, hreadyout=1 immediately (asynchronous);
  - next read after release completes normally.
- CDMA_AHB2APB_TOUT_EN with TOUT_CYC=4 and pready held 0:
  - ERROR response;
  - psel drops after 4 ACCESS cycles.
